// File: rtl/pll_pkg.sv
// pll_pkg: shared lock-state encoding and default widths for the PLL lock detector
package pll_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } lock_state_e;
    localparam int ERR_W_DEF   = 32;
    localparam int LOCK_TIME_W = 16;
endpackage

// File: rtl/pll_err_mag.sv
// pll_err_mag: |err| in ERR_W+1 bits and good/bad classification against the lock tolerances
// Ports: i_err (signed phase error), o_good (|err| <= LOCK_TOL), o_bad (|err| > UNLOCK_TOL)
module pll_err_mag #(
    parameter int ERR_W      = 32,
    parameter int LOCK_TOL   = 4,
    parameter int UNLOCK_TOL = 16
)(
    input  logic signed [ERR_W-1:0] i_err,
    output logic                    o_good,
    output logic                    o_bad
);
    logic [ERR_W:0] w_ext;
    logic [ERR_W:0] w_mag;
    // One extra bit keeps the most negative input from wrapping back to itself
    always_comb begin
        w_ext  = {i_err[ERR_W-1], i_err};
        w_mag  = i_err[ERR_W-1] ? -w_ext : w_ext;
        o_good = w_mag <= (ERR_W+1)'(LOCK_TOL);
        o_bad  = w_mag >  (ERR_W+1)'(UNLOCK_TOL);
    end
endmodule

// File: rtl/pll_lock_detect.sv
// pll_lock_detect: count-plus-tolerance hysteresis lock detector on the PLL phase error
// Ports: i_refclk clock, i_resetn sync active-low reset, i_restart sync clear to IDLE,
//        i_err_valid/i_err phase-error sample, o_locked lock flag, o_lock_state FSM state,
//        o_lost_lock one-cycle pulse on loss of lock, o_lock_time cycles to first lock
//        (o_lock_time only when PLL_LOCK_TIME_EN is defined)
module pll_lock_detect
    import pll_pkg::*;
#(
    parameter int ERR_W      = ERR_W_DEF,
    parameter int LOCK_TOL   = 4,
    parameter int UNLOCK_TOL = 16,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
)(
    input  logic                    i_refclk,
    input  logic                    i_resetn,
    input  logic                    i_restart,
    input  logic                    i_err_valid,
    input  logic signed [ERR_W-1:0] i_err,
    output logic                    o_locked,
    output logic [1:0]              o_lock_state,
    output logic                    o_lost_lock
`ifdef PLL_LOCK_TIME_EN
    ,output logic [LOCK_TIME_W-1:0] o_lock_time
`endif
);
    localparam int CNT_MAX = LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (UNLOCK_TOL < LOCK_TOL || LOCK_CNT < 1 || UNLOCK_CNT < 1) begin : g_param_chk
        $error("pll_lock_detect: invalid tolerance/count parameters");
    end

    lock_state_e      r_state;
    logic [CNT_W-1:0] r_good;
    logic [CNT_W-1:0] r_bad;
    logic             w_good;
    logic             w_bad;
    logic             w_acq;
    logic [CNT_W-1:0] w_gnext;
    logic [CNT_W-1:0] w_bnext;
    logic             w_to_lock;
    logic             w_unlock;

    pll_err_mag #(
        .ERR_W      (ERR_W),
        .LOCK_TOL   (LOCK_TOL),
        .UNLOCK_TOL (UNLOCK_TOL)
    ) u_mag (
        .i_err  (i_err),
        .o_good (w_good),
        .o_bad  (w_bad)
    );

    // Counters are zero on entry to IDLE, LOCKED and ACQ-after-unlock, so the
    // same increment serves the first sample out of IDLE and the SLIP run.
    always_comb begin
        w_acq     = r_state == IDLE || r_state == ACQ;
        w_gnext   = w_good ? r_good + 1'b1 : '0;
        w_bnext   = r_bad + 1'b1;
        w_to_lock = i_err_valid && w_acq && w_gnext == CNT_W'(LOCK_CNT);
        w_unlock  = i_err_valid && !w_acq && w_bad && w_bnext == CNT_W'(UNLOCK_CNT);
    end

    always_ff @(posedge i_refclk) begin
        if (!i_resetn || i_restart) begin
            r_state     <= IDLE;
            r_good      <= '0;
            r_bad       <= '0;
            o_locked    <= 1'b0;
            o_lost_lock <= 1'b0;
        end else begin
            o_lost_lock <= w_unlock;
            if (i_err_valid) begin
                if (w_acq) begin
                    r_state  <= w_to_lock ? LOCKED : ACQ;
                    r_good   <= w_to_lock ? '0 : w_gnext;
                    o_locked <= w_to_lock;
                end else if (w_bad) begin
                    r_state  <= w_unlock ? ACQ : SLIP;
                    r_bad    <= w_unlock ? '0 : w_bnext;
                    o_locked <= !w_unlock;
                end else begin
                    r_state <= LOCKED;
                    r_bad   <= '0;
                end
            end
        end
    end

    assign o_lock_state = r_state;

`ifdef PLL_LOCK_TIME_EN
    logic r_lt_done;
    // Counts every cycle (valid or not) until the first lock, then freezes for good
    always_ff @(posedge i_refclk) begin
        if (!i_resetn || i_restart) begin
            o_lock_time <= '0;
            r_lt_done   <= 1'b0;
        end else begin
            if (!r_lt_done && o_lock_time != '1)
                o_lock_time <= o_lock_time + 1'b1;
            if (w_to_lock)
                r_lt_done <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pll_lock_detect.sv
// tb_pll_lock_detect: directed plus randomized check of pll_lock_detect against a behavioural model
module tb_pll_lock_detect;
    localparam int LT = 4, UT = 16, LC = 16, UC = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        restart = 1'b0;
    logic        err_valid = 1'b0;
    logic [31:0] err = '0;
    logic        locked;
    logic [1:0]  lock_state;
    logic        lost_lock;
`ifdef PLL_LOCK_TIME_EN
    logic [15:0] lock_time;
`endif

    int n_vec = 0;
    int n_err = 0;

    // model: mode 0 idle, 1 acquiring, 2 locked, 3 slipping
    int m_mode = 0, m_good = 0, m_bad = 0, m_lt = 0;
    bit m_lost = 0, m_ever = 0;

    always #5 clk = ~clk;

    pll_lock_detect #(
        .ERR_W(32), .LOCK_TOL(LT), .UNLOCK_TOL(UT), .LOCK_CNT(LC), .UNLOCK_CNT(UC)
    ) dut (
        .i_refclk     (clk),
        .i_resetn     (resetn),
        .i_restart    (restart),
        .i_err_valid  (err_valid),
        .i_err        (err),
        .o_locked     (locked),
        .o_lock_state (lock_state),
        .o_lost_lock  (lost_lock)
`ifdef PLL_LOCK_TIME_EN
        ,.o_lock_time (lock_time)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model(input bit rn, input bit rs, input bit v, input logic [31:0] e);
        longint se, mag;
        if (!rn || rs) begin
            m_mode = 0; m_good = 0; m_bad = 0; m_lt = 0; m_lost = 0; m_ever = 0;
            return;
        end
        m_lost = 0;
        if (!m_ever && m_lt < 65535) m_lt++;
        if (!v) return;
        se  = longint'($signed(e));
        mag = se < 0 ? -se : se;
        if (m_mode < 2) begin
            m_good = (mag <= LT) ? m_good + 1 : 0;
            m_mode = 1;
            if (m_good == LC) begin
                m_mode = 2; m_good = 0; m_ever = 1;
            end
        end else if (mag > UT) begin
            m_bad++;
            m_mode = 3;
            if (m_bad == UC) begin
                m_mode = 1; m_bad = 0; m_good = 0; m_lost = 1;
            end
        end else begin
            m_mode = 2; m_bad = 0;
        end
    endfunction

    task automatic step(input bit rn, input bit rs, input bit v, input logic [31:0] e);
        resetn = rn; restart = rs; err_valid = v; err = e;
        @(posedge clk);
        model(rn, rs, v, e);
        #1;
        chk("locked", 32'(locked), 32'(m_mode >= 2));
        chk("lock_state", 32'(lock_state), 32'(m_mode));
        chk("lost_lock", 32'(lost_lock), 32'(m_lost));
`ifdef PLL_LOCK_TIME_EN
        chk("lock_time", 32'(lock_time), 32'(m_lt));
`endif
    endtask

    task automatic run(input int n, input logic [31:0] e);
        for (int i = 0; i < n; i++) step(1, 0, 1, e);
    endtask

    initial begin
        logic [31:0] e;
        int sel;
        step(0, 0, 0, 0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_state", 32'(lock_state), 32'd0);
        run(15, 3);
        chk("no_early_lock", 32'(locked), 32'd0);
        run(1, 3);
        chk("lock_at_16", 32'(lock_state), 32'd2);
        step(1, 1, 0, 0);
        run(15, -32'sd4);
        run(1, 5);
        run(15, 0);
        chk("no_lock_at_31", 32'(locked), 32'd0);
        run(1, 0);
        chk("lock_at_32", 32'(locked), 32'd1);
        run(3, 20);
        chk("slip_state", 32'(lock_state), 32'd3);
        chk("slip_locked", 32'(locked), 32'd1);
        run(1, 10);
        chk("slip_recover", 32'(lock_state), 32'd2);
        run(3, -32'sd17);
        run(1, -32'sd17);
        chk("unlock_pulse", 32'(lost_lock), 32'd1);
        chk("unlock_state", 32'(lock_state), 32'd1);
        run(1, 0);
        chk("pulse_single", 32'(lost_lock), 32'd0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 0);
            if (i < 10) step(1, 0, 0, 500);
        end
        chk("interleaved_lock", 32'(locked), 32'd1);
        step(1, 1, 0, 0);
        run(10, 1);
        run(1, 32'h8000_0000);
        run(15, 0);
        chk("minneg_clears", 32'(locked), 32'd0);
        run(1, 0);
        run(1, 20);
        chk("in_slip", 32'(lock_state), 32'd3);
        step(0, 0, 1, 20);
        chk("reset_in_slip", 32'({locked, lock_state, lost_lock}), 32'd0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        run(16, 2);
`ifdef PLL_LOCK_TIME_EN
        chk("lock_time_20", 32'(lock_time), 32'd20);
        run(6, 30);
        run(5, 0);
        chk("lock_time_held", 32'(lock_time), 32'd20);
`endif
        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      e = 32'($signed(int'($urandom_range(0, 8)) - 4));
            else if (sel < 75) e = 32'($signed(int'($urandom_range(0, 24)) - 12));
            else if (sel < 90) e = 32'($signed(int'($urandom_range(0, 60)) - 30));
            else if (sel < 93) e = 32'h8000_0000;
            else               e = $urandom;
            step($urandom_range(0, 399) != 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) < 8, e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
